// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the pipelined MIPS core.
// Owns the PC and issues in-order, credit-limited imem requests.
// Buffers returned words and drives the IF/ID register inputs.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   stall             IF/ID hold (queue head is not consumed)
//   redirect          taken branch/jump pulse
//   redirect_pc       redirect target, low two bits ignored
//   imem_req_valid    request channel valid
//   imem_req_ready    request channel ready
//   imem_req_addr     word-aligned fetch address (the PC)
//   imem_resp_valid   in-order response, always accepted
//   imem_resp_data    returned instruction word
//   pc_plus4_out      to IF/ID pc_plus4_in (0 when bubble)
//   instr_out         to IF/ID instr_in (0 when bubble)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc;

    logic [31:0]   pend_mem [DEPTH];
    logic [PW-1:0] pend_rd;
    logic [PW-1:0] pend_wr;
    logic [CW-1:0] pend_cnt;

    logic [31:0]   q_pc4 [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] q_rd;
    logic [PW-1:0] q_wr;
    logic [CW-1:0] q_cnt;

    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] inflight;
    logic [CW:0]   occ;

    logic          issue;
    logic          resp_take;
    logic          resp_drop;
    logic          pop;
    logic          show;
    logic          unused;

    function automatic logic [PW-1:0] wrap_inc(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused = ^redirect_pc[1:0];

    // Responses still owed by memory, stale or not.
    assign inflight = drop_cnt + pend_cnt;

    // Stale in-flight responses keep holding their credit.
    assign occ = {1'b0, inflight} + {1'b0, q_cnt};

    assign imem_req_valid = !reset && !redirect && (occ < DEPTH_W);
    assign imem_req_addr  = pc;

    assign issue     = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (drop_cnt == '0)
                    && (pend_cnt != '0);
    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign pop       = !stall && (q_cnt != '0);
    assign show      = !reset && !redirect && (q_cnt != '0);

    always_comb begin
        pc_plus4_out = '0;
        instr_out    = '0;
        if (show) begin
            pc_plus4_out = q_pc4[q_rd];
            instr_out    = q_instr[q_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            q_cnt    <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            q_cnt    <= '0;
            // A response landing now settles one of the owed ones.
            drop_cnt <= inflight
                      - CW'(imem_resp_valid && (inflight != '0));
        end else begin
            if (issue) begin
                pc      <= pc + 32'd4;
                pend_wr <= wrap_inc(pend_wr);
            end
            if (resp_take) begin
                pend_rd <= wrap_inc(pend_rd);
                q_wr    <= wrap_inc(q_wr);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (pop) begin
                q_rd <= wrap_inc(q_rd);
            end
            pend_cnt <= pend_cnt + CW'(issue) - CW'(resp_take);
            q_cnt    <= q_cnt + CW'(resp_take) - CW'(pop);
        end
    end

    // Storage arrays need no reset; counts qualify their contents.
    always_ff @(posedge clk) begin
        if (!reset && !redirect) begin
            if (issue) begin
                pend_mem[pend_wr] <= pc + 32'd4;
            end
            if (resp_take) begin
                q_pc4[q_wr]   <= pend_mem[pend_rd];
                q_instr[q_wr] <= imem_resp_data;
            end
        end
    end

    // A response with nothing owed is a memory protocol error.
    always_ff @(posedge clk) begin
        if (!reset && imem_resp_valid) begin
            assert (inflight != '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit.
// Queue-level reference model plus a variable-latency memory model.
module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .pc_plus4_out   (pc_plus4_out),
        .instr_out      (instr_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    int          lat_min = 1;
    int          lat_max = 1;

    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic [63:0] m_outq[$];
    int          m_drop = 0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    logic [31:0] iss_log[$];
    logic [63:0] out_log[$];
    int          out_cyc[$];
    logic        obs_valid;
    logic [31:0] obs_addr;
    logic [31:0] obs_p4;
    logic [31:0] obs_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        return (i < iss_log.size()) ? iss_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [63:0] out_at(input int i);
        return (i < out_log.size()) ? out_log[i] : {64{1'bx}};
    endfunction

    function automatic int cyc_at(input int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h, want %h",
                     name, cyc, act, exp);
        end
    endtask

    // One clock: memory drives, outputs checked, model advanced.
    task automatic step();
        logic        rv;
        logic [31:0] rd;
        logic        ev;
        logic        iss;
        logic [63:0] head;
        logic [31:0] cur_pc;
        logic [31:0] h;
        int          occ;
        rv = 1'b0;
        rd = '0;
        if (reset) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rv = 1'b1;
            rd = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        #1;
        occ  = m_pend.size() + m_outq.size() + m_drop;
        ev   = !reset && !redirect && (occ < DEPTH);
        head = (reset || redirect || m_outq.size() == 0)
             ? 64'd0 : m_outq[0];
        check("req_valid", 32'(imem_req_valid), 32'(ev));
        if (ev) check("req_addr", imem_req_addr, m_pc);
        check("pc_plus4_out", pc_plus4_out, head[63:32]);
        check("instr_out", instr_out, head[31:0]);

        obs_valid = imem_req_valid;
        obs_addr  = imem_req_addr;
        obs_p4    = pc_plus4_out;
        obs_in    = instr_out;
        if (imem_req_valid && imem_req_ready)
            iss_log.push_back(imem_req_addr);
        if (!reset && !redirect && !stall && instr_out != 0) begin
            out_log.push_back({pc_plus4_out, instr_out});
            out_cyc.push_back(cyc);
        end

        iss    = ev && imem_req_ready;
        cur_pc = m_pc;
        if (reset) begin
            m_pc   = RST_PC;
            m_drop = 0;
            m_pend.delete();
            m_outq.delete();
        end else if (redirect) begin
            m_drop = m_drop + m_pend.size() - (rv ? 1 : 0);
            m_pend.delete();
            m_outq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (!stall && m_outq.size() > 0) void'(m_outq.pop_front());
            if (rv) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else if (m_pend.size() > 0) begin
                    h = m_pend.pop_front();
                    m_outq.push_back({h, rd});
                end
            end
            if (iss) begin
                m_pend.push_back(m_pc + 32'd4);
                m_pc = m_pc + 32'd4;
            end
        end
        if (iss)
            mem_q.push_back('{cur_pc,
                cyc + int'($urandom_range(lat_max, lat_min))});
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_logs();
        iss_log.delete();
        out_log.delete();
        out_cyc.delete();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        reset = 1'b0;
        clear_logs();
    endtask

    int rc;

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        @(negedge clk);

        // Zero-wait streaming from reset.
        lat_min = 1;
        lat_max = 1;
        imem_req_ready = 1'b1;
        do_reset();
        rc = cyc - 1;
        check("reset_req_valid", 32'(obs_valid), 32'd0);
        check("reset_pc4", obs_p4, 32'd0);
        check("reset_instr", obs_in, 32'd0);
        repeat (12) step();
        check("start_addr0", iss_at(0), 32'h0);
        check("start_addr1", iss_at(1), 32'h4);
        check("start_addr2", iss_at(2), 32'h8);
        check("start_out0_pc4", out_at(0)[63:32], 32'h4);
        check("start_out0_instr", out_at(0)[31:0], 32'hA000_0000);
        check("start_out1_pc4", out_at(1)[63:32], 32'h8);
        check("start_out1_instr", out_at(1)[31:0], 32'hA000_0004);
        check("start_latency", 32'(cyc_at(0) - rc), 32'd3);

        // Long stall fills the credits, then release.
        stall = 1'b1;
        repeat (5) step();
        check("stall_full_valid", 32'(obs_valid), 32'd0);
        stall = 1'b0;
        repeat (10) step();

        // Memory back-pressure holds the address.
        do_reset();
        step();
        step();
        imem_req_ready = 1'b0;
        repeat (3) step();
        check("bp_valid", 32'(obs_valid), 32'd1);
        check("bp_addr", obs_addr, 32'h8);
        check("bp_pc4", obs_p4, 32'd0);
        check("bp_instr", obs_in, 32'd0);
        imem_req_ready = 1'b1;
        repeat (6) step();

        // Redirect with two slow responses outstanding.
        lat_min = 3;
        lat_max = 3;
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        clear_logs();
        repeat (15) step();
        check("redir_addr", iss_at(0), 32'h100);
        check("redir_out_pc4", out_at(0)[63:32], 32'h104);
        check("redir_out_instr", out_at(0)[31:0], 32'hA000_0100);

        // Redirect colliding with stall and a response.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        step();
        step();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        check("coll_valid", 32'(obs_valid), 32'd1);
        check("coll_addr", obs_addr, 32'h200);
        check("coll_pc4", obs_p4, 32'd0);
        check("coll_instr", obs_in, 32'd0);
        repeat (4) step();

        // PC wrap across the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        clear_logs();
        repeat (15) step();
        check("wrap_addr0", iss_at(0), 32'hFFFF_FFF8);
        check("wrap_addr1", iss_at(1), 32'hFFFF_FFFC);
        check("wrap_addr2", iss_at(2), 32'h0000_0000);
        check("wrap_pc4_0", out_at(0)[63:32], 32'hFFFF_FFFC);
        check("wrap_pc4_1", out_at(1)[63:32], 32'h0000_0000);
        check("wrap_pc4_2", out_at(2)[63:32], 32'h0000_0004);

        // Randomized traffic.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(199, 0) == 0);
            stall          = ($urandom_range(99, 0) < 30);
            redirect       = !redirect && ($urandom_range(99, 0) < 5);
            redirect_pc    = $urandom();
            imem_req_ready = ($urandom_range(99, 0) < 70);
            step();
        end
        reset    = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
